// File: rtl/enc_layer_seq_if.sv
// Bundle of the three channels around enc_layer_seq:
//   upstream   : in_valid / in_ready / in_x       (vector in, valid/ready)
//   engine     : eng_start / eng_row / eng_x      (sequencer -> dot-product engine)
//                eng_done / eng_y                 (engine -> sequencer)
//   downstream : out_valid / out_ready / out_y    (packed layer result, valid/ready)
// slave  : the sequencer's view.
// master : the environment's view (upstream source, engine, downstream sink).
interface enc_layer_seq_if #(
  parameter int BITSIZE = 16,
  parameter int N_IN    = 6,
  parameter int N_OUT   = 4
);
  localparam int RW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [BITSIZE*N_IN-1:0]   in_x;
  logic                      eng_start;
  logic [RW-1:0]             eng_row;
  logic [BITSIZE*N_IN-1:0]   eng_x;
  logic                      eng_done;
  logic [BITSIZE-1:0]        eng_y;
  logic                      out_valid;
  logic                      out_ready;
  logic [BITSIZE*N_OUT-1:0]  out_y;

  modport slave (
    input  in_valid, in_x, eng_done, eng_y, out_ready,
    output in_ready, eng_start, eng_row, eng_x, out_valid, out_y
  );

  modport master (
    output in_valid, in_x, eng_done, eng_y, out_ready,
    input  in_ready, eng_start, eng_row, eng_x, out_valid, out_y
  );
endinterface

// File: rtl/enc_layer_seq.sv
// Encoder layer sequencer: shares one single-row dot-product engine across
// the N_OUT rows of a layer. A captured input vector is held on the engine
// for the whole layer, one start is issued per row, results are gathered
// into a packed vector and offered downstream.
// Ports:
//   clk_i    : clock, rising edge
//   reset_i  : synchronous, active-high reset
//   bus      : enc_layer_seq_if.slave (upstream, engine and downstream channels)
//   busy_o   : high whenever the sequencer is not idle
//   err_o    : sticky engine-timeout flag, cleared by the next accepted vector
//
// state  | meaning
// IDLE   | waiting for an input vector (in_ready=1)
// ISSUE  | one-cycle engine start for the current row
// WAIT   | waiting for eng_done, timeout counter running
// OUT    | layer result presented until out_ready
module enc_layer_seq #(
  parameter int BITSIZE = 16,
  parameter int N_IN    = 6,
  parameter int N_OUT   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  enc_layer_seq_if.slave    bus,
  output logic              busy_o,
  output logic              err_o
);
  localparam int RW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int XW = BITSIZE * N_IN;
  localparam int YW = BITSIZE * N_OUT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  res_q, res_d;
  logic           err_q, err_d;

  logic           last_row;
  logic           tmo_tc;
  logic           in_ready;
  logic           eng_start;
  logic           out_valid;
  logic           busy;

  assign last_row = (row_q == RW'(N_OUT - 1));
  // Down-counter loaded in ISSUE; reaching zero marks the TIMEOUT-th WAIT cycle.
  assign tmo_tc   = (tmo_q == '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      tmo_q   <= '0;
      x_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      tmo_q   <= tmo_d;
      x_q     <= x_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    tmo_d   = tmo_q;
    x_d     = x_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.in_x;
          row_d   = '0;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = TW'(TIMEOUT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // eng_done is checked first so it wins over a same-cycle timeout.
        if (bus.eng_done) begin
          res_d[BITSIZE*int'(row_q) +: BITSIZE] = bus.eng_y;
          if (last_row) begin
            state_d = S_OUT;
          end else begin
            row_d   = row_q + RW'(1);
            state_d = S_ISSUE;
          end
        end else if (tmo_tc) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    eng_start = (state_q == S_ISSUE);
    out_valid = (state_q == S_OUT);
    busy      = (state_q != S_IDLE);
  end

  assign bus.in_ready  = in_ready;
  assign bus.eng_start = eng_start;
  assign bus.eng_row   = row_q;
  assign bus.eng_x     = x_q;
  assign bus.out_valid = out_valid;
  assign bus.out_y     = res_q;
  assign busy_o        = busy;
  assign err_o         = err_q;
endmodule

// File: tb/tb_enc_layer_seq.sv
module tb_enc_layer_seq;
  localparam int BITSIZE = 16;
  localparam int N_IN    = 6;
  localparam int N_OUT   = 4;
  localparam int TIMEOUT = 64;
  localparam int XW      = BITSIZE * N_IN;
  localparam int YW      = BITSIZE * N_OUT;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic err;
  int   errors = 0;
  int   checks = 0;

  // Engine responses for the layer in flight, one per row.
  logic [BITSIZE-1:0] ys [N_OUT];

  enc_layer_seq_if #(.BITSIZE(BITSIZE), .N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  enc_layer_seq #(
    .BITSIZE(BITSIZE), .N_IN(N_IN), .N_OUT(N_OUT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus),
    .busy_o (busy),
    .err_o  (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready, 1);
    chk({tag, "_eng_start"}, bus.eng_start, 0);
    chk({tag, "_eng_row"},   bus.eng_row, 0);
    chk({tag, "_eng_x"},     bus.eng_x, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_y"},     bus.out_y, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_err"},       err, 0);
  endtask

  // Reference: expected packed result is row r's engine value at slot r.
  function automatic logic [YW-1:0] model_out_y();
    logic [YW-1:0] acc;
    acc = '0;
    for (int r = 0; r < N_OUT; r++) acc = acc | (YW'(ys[r]) << (BITSIZE * r));
    return acc;
  endfunction

  // mode 0: normal, 1: engine silent on row 2, 2: reset during WAIT of row 1.
  // Cycle numbering: handshake cycle is 0, row r starts at 1+r*(lat+1).
  task automatic run_layer(input logic [XW-1:0] x, input int lat, input int mode,
                           input int hold, input bit spurious);
    int c;
    int n;
    int s;
    logic [YW-1:0] exp_y;
    exp_y = model_out_y();
    if (spurious) begin
      @(negedge clk);
      bus.eng_done = 1'b1;
      bus.eng_y    = 16'hdead;
      @(negedge clk);
      bus.eng_done = 1'b0;
      chk("idle_done_busy", busy, 0);
    end
    @(negedge clk);
    chk("hs_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_x     = ~x;
    @(negedge clk);
    c = 1;
    chk("err_cleared", err, 0);
    for (int r = 0; r < N_OUT; r++) begin
      n = 0;
      while (!bus.eng_start && n < 200) begin
        @(negedge clk);
        c++;
        n++;
      end
      chk("start_cycle", c, 1 + r * (lat + 1));
      chk("eng_row", bus.eng_row, r);
      chk("eng_x", bus.eng_x, x);
      chk("in_ready_busy", bus.in_ready, 0);
      s = c;
      if (spurious && r == 0) begin
        bus.eng_done = 1'b1;
        bus.eng_y    = 16'hbeef;
      end
      @(negedge clk);
      c++;
      bus.eng_done = 1'b0;
      chk("start_one_cycle", bus.eng_start, 0);
      if (mode == 2 && r == 1) begin
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_no_start", bus.eng_start, 0);
        chk("midrst_idle", busy, 0);
        return;
      end
      if (mode == 1 && r == 2) begin
        while (c < s + TIMEOUT) begin
          @(negedge clk);
          c++;
        end
        chk("tmo_last_wait_busy", busy, 1);
        chk("tmo_err_not_yet", err, 0);
        @(negedge clk);
        chk("tmo_idle", busy, 0);
        chk("tmo_err", err, 1);
        chk("tmo_no_valid", bus.out_valid, 0);
        chk("tmo_in_ready", bus.in_ready, 1);
        repeat (3) @(negedge clk);
        chk("tmo_no_valid_later", bus.out_valid, 0);
        chk("tmo_err_sticky", err, 1);
        return;
      end
      while (c < s + lat) begin
        @(negedge clk);
        c++;
      end
      bus.eng_done = 1'b1;
      bus.eng_y    = ys[r];
      @(negedge clk);
      c++;
      bus.eng_done = 1'b0;
      bus.eng_y    = 16'($urandom);
    end
    chk("out_cycle", c, N_OUT * (lat + 1) + 1);
    chk("out_valid", bus.out_valid, 1);
    chk("out_y", bus.out_y, exp_y);
    chk("out_in_ready", bus.in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_y", bus.out_y, exp_y);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_dropped", bus.out_valid, 0);
    chk("back_to_idle", busy, 0);
  endtask

  initial begin
    logic [XW-1:0] x;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.eng_done  = 1'b0;
    bus.eng_y     = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_in_ready", bus.in_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_start", bus.eng_start, 0);
      chk("idle_out_y", bus.out_y, 0);
    end

    x = {N_IN{16'h0800}};
    for (int r = 0; r < N_OUT; r++) ys[r] = 16'(16'h0400 + r);
    run_layer(x, 7, 0, 0, 1'b0);
    run_layer(x, 7, 0, 20, 1'b0);
    run_layer(x, 7, 0, 0, 1'b1);

    x = {$urandom, $urandom, $urandom};
    run_layer(x, 5, 1, 0, 1'b0);
    x = {$urandom, $urandom, $urandom};
    for (int r = 0; r < N_OUT; r++) ys[r] = 16'($urandom);
    run_layer(x, 3, 0, 1, 1'b0);

    x = {$urandom, $urandom, $urandom};
    run_layer(x, 4, 2, 0, 1'b0);
    x = {$urandom, $urandom, $urandom};
    for (int r = 0; r < N_OUT; r++) ys[r] = 16'($urandom);
    run_layer(x, 2, 0, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      x = {$urandom, $urandom, $urandom};
      for (int r = 0; r < N_OUT; r++) ys[r] = 16'($urandom);
      run_layer(x, int'($urandom_range(1, 9)), 0, int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
